bsg_serial_array_reverse: RTL and testbench



---
 rtl/bsg_serial_array_reverse.sv | 120 ++++++++++++
 tb/tb_bsg_serial_array_reverse.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/bsg_serial_array_reverse.sv
// Streaming frame reverser: buffers els_p elements, then drains them last-in-first-out.
// Optional last_o frame-end marker is enabled by defining BSG_SERIAL_ARRAY_REVERSE_LAST_EN.
//
// state   | meaning
// --------+-----------------------------------------------------------
// e_fill  | accepting input elements, ptr_r is the next write index
// e_drain | emitting stored elements, ptr_r is the current read index
module bsg_serial_array_reverse #(
    parameter int width_p = 16,
    parameter int els_p   = 64
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               v_i,
    input  logic [width_p-1:0] data_i,
    output logic               ready_o,
    output logic               v_o,
    output logic [width_p-1:0] data_o,
    input  logic               yumi_i
`ifdef BSG_SERIAL_ARRAY_REVERSE_LAST_EN
    ,
    output logic               last_o
`endif
);

    localparam int ptr_w_lp = (els_p > 1) ? $clog2(els_p) : 1;
    localparam logic [ptr_w_lp-1:0] c_last_ptr = ptr_w_lp'(els_p - 1);

    typedef enum logic {
        e_fill  = 1'b0,
        e_drain = 1'b1
    } state_e;

    state_e               r_state;
    state_e               w_state_n;
    logic [ptr_w_lp-1:0]  r_ptr;
    logic [ptr_w_lp-1:0]  w_ptr_n;
    logic                 w_wr_en;
    logic                 w_ready;
    logic                 w_v;
    logic [width_p-1:0]   r_mem [els_p];
    logic [width_p-1:0]   w_rd_data;

    // Outputs are forced low while reset is asserted, independent of the state register.
    assign w_ready = (r_state == e_fill)  & ~reset_i;
    assign w_v     = (r_state == e_drain) & ~reset_i;

    always_comb begin
        w_state_n = r_state;
        w_ptr_n   = r_ptr;
        w_wr_en   = 1'b0;
        case (r_state)
            e_fill: begin
                if (v_i & w_ready) begin
                    w_wr_en = 1'b1;
                    if (r_ptr == c_last_ptr) begin
                        w_state_n = e_drain;
                    end else begin
                        w_ptr_n = r_ptr + 1'b1;
                    end
                end
            end
            e_drain: begin
                if (yumi_i & w_v) begin
                    if (r_ptr == '0) begin
                        w_state_n = e_fill;
                    end else begin
                        w_ptr_n = r_ptr - 1'b1;
                    end
                end
            end
            default: begin
                w_state_n = e_fill;
                w_ptr_n   = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_state <= e_fill;
            r_ptr   <= '0;
        end else begin
            r_state <= w_state_n;
            r_ptr   <= w_ptr_n;
        end
    end

    // Storage is intentionally not reset; only the pointer and state define validity.
    generate
        if (els_p == 1) begin : g_single
            always_ff @(posedge clk_i) begin
                if (w_wr_en) begin
                    r_mem[0] <= data_i;
                end
            end
            assign w_rd_data = r_mem[0];
        end else begin : g_multi
            always_ff @(posedge clk_i) begin
                if (w_wr_en) begin
                    r_mem[r_ptr] <= data_i;
                end
            end
            assign w_rd_data = r_mem[r_ptr];
        end
    endgenerate

    assign ready_o = w_ready;
    assign v_o     = w_v;
    assign data_o  = w_rd_data;

`ifdef BSG_SERIAL_ARRAY_REVERSE_LAST_EN
    assign last_o = w_v & (r_ptr == '0);
`endif

`ifndef SYNTHESIS
    a_yumi_needs_valid: assert property (@(posedge clk_i) disable iff (reset_i) yumi_i |-> v_o);
`endif

endmodule

// File: tb/tb_bsg_serial_array_reverse.sv
// Directed bench for bsg_serial_array_reverse: table-driven els_p=4 vectors,
// plus hand sequences for els_p=64 with random gaps/stalls and for els_p=1.
module tb_bsg_serial_array_reverse;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", nm, act, exp);
        end
    endtask

    // ---------------- instance a: els_p = 4 ----------------
    logic        a_v = 1'b0, a_y = 1'b0, a_rdy, a_vo, a_last;
    logic [15:0] a_d = '0, a_do;
    bsg_serial_array_reverse #(.width_p(16), .els_p(4)) u_a (
        .clk_i(clk), .reset_i(reset), .v_i(a_v), .data_i(a_d),
        .ready_o(a_rdy), .v_o(a_vo), .data_o(a_do), .yumi_i(a_y)
`ifdef BSG_SERIAL_ARRAY_REVERSE_LAST_EN
        , .last_o(a_last)
`endif
    );
`ifndef BSG_SERIAL_ARRAY_REVERSE_LAST_EN
    assign a_last = 1'b0;
`endif

    // ---------------- instance b: els_p = 64 ----------------
    logic        b_v = 1'b0, b_y = 1'b0, b_rdy, b_vo, b_last;
    logic [15:0] b_d = '0, b_do;
    bsg_serial_array_reverse #(.width_p(16), .els_p(64)) u_b (
        .clk_i(clk), .reset_i(reset), .v_i(b_v), .data_i(b_d),
        .ready_o(b_rdy), .v_o(b_vo), .data_o(b_do), .yumi_i(b_y)
`ifdef BSG_SERIAL_ARRAY_REVERSE_LAST_EN
        , .last_o(b_last)
`endif
    );
`ifndef BSG_SERIAL_ARRAY_REVERSE_LAST_EN
    assign b_last = 1'b0;
`endif

    // ---------------- instance c: els_p = 1 ----------------
    logic        c_v = 1'b0, c_y = 1'b0, c_rdy, c_vo, c_last;
    logic [15:0] c_d = '0, c_do;
    bsg_serial_array_reverse #(.width_p(16), .els_p(1)) u_c (
        .clk_i(clk), .reset_i(reset), .v_i(c_v), .data_i(c_d),
        .ready_o(c_rdy), .v_o(c_vo), .data_o(c_do), .yumi_i(c_y)
`ifdef BSG_SERIAL_ARRAY_REVERSE_LAST_EN
        , .last_o(c_last)
`endif
    );
`ifndef BSG_SERIAL_ARRAY_REVERSE_LAST_EN
    assign c_last = 1'b0;
`endif

    typedef struct {
        logic        rst;
        logic        v;
        logic [15:0] d;
        logic        y;
        logic        e_rdy;
        logic        e_v;
        logic [15:0] e_d;
        logic        e_last;
    } vec_t;

    vec_t tv[$];

    task automatic add(input logic rst, input logic v, input logic [15:0] d, input logic y,
                       input logic e_rdy, input logic e_v, input logic [15:0] e_d, input logic e_last);
        vec_t t;
        t.rst = rst; t.v = v; t.d = d; t.y = y;
        t.e_rdy = e_rdy; t.e_v = e_v; t.e_d = e_d; t.e_last = e_last;
        tv.push_back(t);
    endtask

    task automatic run_frame_b(input int base);
        int k;
        int n;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            while ($urandom_range(0, 3) == 0) begin
                b_v = 1'b0;
                #1 chk("b_fill_ready_gap", {31'd0, b_rdy}, 32'd1);
                @(negedge clk);
            end
            b_v = 1'b1;
            b_d = 16'(base + i);
            #1;
            chk($sformatf("b_fill_ready[%0d]", i), {31'd0, b_rdy}, 32'd1);
            chk($sformatf("b_fill_nov[%0d]", i), {31'd0, b_vo}, 32'd0);
        end
        @(negedge clk);
        b_v = 1'b1;
        b_d = 16'hFFFF;
        k = 63;
        n = 0;
        while (k >= 0 && n < 400) begin
            #1;
            chk($sformatf("b_drain_v[%0d]", k), {31'd0, b_vo}, 32'd1);
            chk($sformatf("b_drain_rdy[%0d]", k), {31'd0, b_rdy}, 32'd0);
            chk($sformatf("b_drain_data[%0d]", k), {16'd0, b_do}, 32'(16'(base + k)));
            if (b_vo && $urandom_range(0, 2) != 0) begin
                b_y = 1'b1;
                k--;
            end else begin
                b_y = 1'b0;
            end
            @(negedge clk);
            b_y = 1'b0;
            n++;
        end
        b_v = 1'b0;
        chk("b_drain_done", 32'(k), 32'hFFFF_FFFF);
        #1;
        chk("b_after_ready", {31'd0, b_rdy}, 32'd1);
        chk("b_after_nov", {31'd0, b_vo}, 32'd0);
    endtask

    initial begin
        // rst v  d        y     rdy  v  data     last
        add(1, 0, 16'h0,    0,   0, 0, 16'h0,    0);
        add(1, 0, 16'h0,    0,   0, 0, 16'h0,    0);
        add(0, 1, 16'h000A, 0,   1, 0, 16'h0,    0);
        add(0, 1, 16'h000B, 0,   1, 0, 16'h0,    0);
        add(0, 1, 16'h000C, 0,   1, 0, 16'h0,    0);
        add(0, 1, 16'h000D, 0,   1, 0, 16'h0,    0);
        add(0, 0, 16'h0,    1,   0, 1, 16'h000D, 0);
        add(0, 0, 16'h0,    1,   0, 1, 16'h000C, 0);
        add(0, 0, 16'h0,    1,   0, 1, 16'h000B, 0);
        add(0, 0, 16'h0,    1,   0, 1, 16'h000A, 1);
        add(0, 0, 16'h0,    0,   1, 0, 16'h0,    0);
        // abort a partial frame with reset
        add(0, 1, 16'h0011, 0,   1, 0, 16'h0,    0);
        add(0, 1, 16'h0022, 0,   1, 0, 16'h0,    0);
        add(1, 0, 16'h0,    0,   0, 0, 16'h0,    0);
        add(0, 1, 16'h0001, 0,   1, 0, 16'h0,    0);
        add(0, 1, 16'h0002, 0,   1, 0, 16'h0,    0);
        add(0, 1, 16'h0003, 0,   1, 0, 16'h0,    0);
        add(0, 1, 16'h0004, 0,   1, 0, 16'h0,    0);
        add(0, 0, 16'h0,    0,   0, 1, 16'h0004, 0);
        add(0, 0, 16'h0,    1,   0, 1, 16'h0004, 0);
        add(0, 0, 16'h0,    1,   0, 1, 16'h0003, 0);
        add(0, 0, 16'h0,    1,   0, 1, 16'h0002, 0);
        add(0, 0, 16'h0,    1,   0, 1, 16'h0001, 1);
        add(0, 0, 16'h0,    0,   1, 0, 16'h0,    0);
        // reset in the middle of a drain; v_i during drain is ignored
        add(0, 1, 16'h0005, 0,   1, 0, 16'h0,    0);
        add(0, 1, 16'h0006, 0,   1, 0, 16'h0,    0);
        add(0, 1, 16'h0007, 0,   1, 0, 16'h0,    0);
        add(0, 1, 16'h0008, 0,   1, 0, 16'h0,    0);
        add(0, 1, 16'hFFFF, 1,   0, 1, 16'h0008, 0);
        add(0, 0, 16'h0,    1,   0, 1, 16'h0007, 0);
        add(1, 0, 16'h0,    0,   0, 0, 16'h0,    0);
        add(0, 0, 16'h0,    0,   1, 0, 16'h0,    0);
        add(0, 1, 16'h0009, 0,   1, 0, 16'h0,    0);
        add(0, 1, 16'h000A, 0,   1, 0, 16'h0,    0);
        add(0, 1, 16'h000B, 0,   1, 0, 16'h0,    0);
        add(0, 1, 16'h000C, 0,   1, 0, 16'h0,    0);
        add(0, 0, 16'h0,    1,   0, 1, 16'h000C, 0);
        add(0, 0, 16'h0,    1,   0, 1, 16'h000B, 0);
        add(0, 0, 16'h0,    1,   0, 1, 16'h000A, 0);
        add(0, 0, 16'h0,    1,   0, 1, 16'h0009, 1);
        add(0, 0, 16'h0,    0,   1, 0, 16'h0,    0);

        foreach (tv[i]) begin
            @(negedge clk);
            reset = tv[i].rst;
            a_v   = tv[i].v;
            a_d   = tv[i].d;
            a_y   = tv[i].y;
            #1;
            chk($sformatf("a_ready[%0d]", i), {31'd0, a_rdy}, {31'd0, tv[i].e_rdy});
            chk($sformatf("a_valid[%0d]", i), {31'd0, a_vo}, {31'd0, tv[i].e_v});
            if (tv[i].e_v)
                chk($sformatf("a_data[%0d]", i), {16'd0, a_do}, {16'd0, tv[i].e_d});
`ifdef BSG_SERIAL_ARRAY_REVERSE_LAST_EN
            chk($sformatf("a_last[%0d]", i), {31'd0, a_last}, {31'd0, tv[i].e_last});
`endif
        end
        @(negedge clk);
        a_v = 1'b0;
        a_y = 1'b0;
        reset = 1'b0;

        run_frame_b(0);
        run_frame_b(16'h0100);

        // els_p = 1: each element is its own frame
        @(negedge clk);
        c_v = 1'b1; c_d = 16'h1234; c_y = 1'b0;
        #1 chk("c_rdy0", {31'd0, c_rdy}, 32'd1);
        chk("c_v0", {31'd0, c_vo}, 32'd0);
        @(negedge clk);
        c_v = 1'b0; c_y = 1'b1;
        #1 chk("c_rdy1", {31'd0, c_rdy}, 32'd0);
        chk("c_v1", {31'd0, c_vo}, 32'd1);
        chk("c_d1", {16'd0, c_do}, 32'h1234);
`ifdef BSG_SERIAL_ARRAY_REVERSE_LAST_EN
        chk("c_last1", {31'd0, c_last}, 32'd1);
`endif
        @(negedge clk);
        c_v = 1'b1; c_d = 16'h5678; c_y = 1'b0;
        #1 chk("c_rdy2", {31'd0, c_rdy}, 32'd1);
        chk("c_v2", {31'd0, c_vo}, 32'd0);
        @(negedge clk);
        c_v = 1'b0; c_y = 1'b1;
        #1 chk("c_rdy3", {31'd0, c_rdy}, 32'd0);
        chk("c_v3", {31'd0, c_vo}, 32'd1);
        chk("c_d3", {16'd0, c_do}, 32'h5678);
`ifdef BSG_SERIAL_ARRAY_REVERSE_LAST_EN
        chk("c_last3", {31'd0, c_last}, 32'd1);
`endif
        @(negedge clk);
        c_y = 1'b0;
        #1 chk("c_rdy4", {31'd0, c_rdy}, 32'd1);
        chk("c_v4", {31'd0, c_vo}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
